// File: rtl/window_gen_3x3_if.sv
// Pixel-stream / window-stream bundle between the pixel source, the 3x3
// window generator and the downstream conv stage.
interface window_gen_3x3_if #(
  parameter int PW = 12
);
  logic [PW-1:0]   i_pixel;
  logic            i_pixel_valid;
  logic [9*PW-1:0] o_window;
  logic            o_window_valid;
  logic            o_frame_done;

  // Pixel source side: drives pixels, observes the produced windows
  modport master (
    output i_pixel,
    output i_pixel_valid,
    input  o_window,
    input  o_window_valid,
    input  o_frame_done
  );

  // Window generator side
  modport slave (
    input  i_pixel,
    input  i_pixel_valid,
    output o_window,
    output o_window_valid,
    output o_frame_done
  );
endinterface

// File: rtl/window_gen_3x3.sv
// 3x3 sliding-window generator. Two line buffers hold the previous two rows;
// a 3x3 register window shifts left on every accepted pixel. One window is
// emitted (registered, 1-cycle latency) per accepted pixel at row>=2, col>=2.
module window_gen_3x3 #(
  parameter int INTEGER_BITS     = 8,
  parameter int FIXED_POINT_BITS = 4,
  parameter int IMG_WIDTH        = 28,
  parameter int IMG_HEIGHT       = 28
) (
  input  logic             i_clk,
  input  logic             i_rst,
  window_gen_3x3_if.slave  bus
);
  localparam int PW = INTEGER_BITS + FIXED_POINT_BITS;
  localparam int CW = (IMG_WIDTH  > 2) ? $clog2(IMG_WIDTH)  : 2;
  localparam int RW = (IMG_HEIGHT > 2) ? $clog2(IMG_HEIGHT) : 2;
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(IMG_HEIGHT - 1);

  typedef enum logic [0:0] {
    ST_FILL   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  state_t          r_state, w_state_next;
  logic [CW-1:0]   r_col, w_col_next;
  logic [RW-1:0]   r_row, w_row_next;
  logic [PW-1:0]   r_lb0 [IMG_WIDTH];   // row r-2
  logic [PW-1:0]   r_lb1 [IMG_WIDTH];   // row r-1
  logic [9*PW-1:0] r_window;
  logic            r_window_valid;
  logic            r_frame_done;
  logic [9*PW-1:0] w_window_next;
  logic            w_accept;
  logic            w_last_col;
  logic            w_last_row;
  logic            w_frame_end;
  logic            w_emit;

  // Reset is given priority in every register block, so a raw valid is enough here
  assign w_accept    = bus.i_pixel_valid;
  assign w_last_col  = (r_col == LAST_COL);
  assign w_last_row  = (r_row == LAST_ROW);
  assign w_frame_end = w_accept && w_last_col && w_last_row;
  // Columns 0 and 1 are suppressed so a window never straddles a row boundary
  assign w_emit      = w_accept && (r_state == ST_STREAM) && (r_col >= CW'(2));

  // Shifted window: drop the left column, append {row r-2, row r-1, new pixel}
  assign w_window_next = {r_window[8*PW-1:6*PW], r_lb0[r_col],
                          r_window[5*PW-1:3*PW], r_lb1[r_col],
                          r_window[2*PW-1:0],    bus.i_pixel};

  // Next-state logic for raster counters and FILL/STREAM phase
  always_comb begin
    w_col_next   = r_col;
    w_row_next   = r_row;
    w_state_next = r_state;
    if (w_accept) begin
      if (w_last_col) begin
        w_col_next = '0;
        if (w_last_row) begin
          w_row_next = '0;
        end else begin
          w_row_next = r_row + RW'(1);
        end
      end else begin
        w_col_next = r_col + CW'(1);
      end
    end else begin
      w_col_next = r_col;
    end
    case (r_state)
      ST_FILL: begin
        if (w_accept && w_last_col && (r_row == RW'(1))) begin
          w_state_next = ST_STREAM;
        end else begin
          w_state_next = ST_FILL;
        end
      end
      ST_STREAM: begin
        if (w_frame_end) begin
          w_state_next = ST_FILL;
        end else begin
          w_state_next = ST_STREAM;
        end
      end
      default: w_state_next = ST_FILL;
    endcase
  end

  // State and raster-position registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_FILL;
      r_col   <= '0;
      r_row   <= '0;
    end else begin
      r_state <= w_state_next;
      r_col   <= w_col_next;
      r_row   <= w_row_next;
    end
  end

  // Line buffers: read-before-write at the current column; contents never cleared
  always_ff @(posedge i_clk) begin
    if (w_accept && !i_rst) begin
      r_lb0[r_col] <= r_lb1[r_col];
      r_lb1[r_col] <= bus.i_pixel;
    end
  end

  // Window shift register and registered output flags; idle cycles hold the window
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_window       <= '0;
      r_window_valid <= 1'b0;
      r_frame_done   <= 1'b0;
    end else if (w_accept) begin
      r_window       <= w_window_next;
      r_window_valid <= w_emit;
      r_frame_done   <= w_frame_end;
    end else begin
      r_window_valid <= 1'b0;
      r_frame_done   <= 1'b0;
    end
  end

  assign bus.o_window       = r_window;
  assign bus.o_window_valid = r_window_valid;
  assign bus.o_frame_done   = r_frame_done;
endmodule
